// File: rtl/dpram_port_sequencer_if.sv
// Requester handshake and RAM-port pin bundle for dpram_port_sequencer.
// master: requesters plus the pad side (drives ad_in); slave: the sequencer.
interface dpram_port_sequencer_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          gnt_id;
  logic          ce_n;
  logic          we_n;
  logic          oe_n;
  logic [DW-1:0] ad_out;
  logic          ad_oe;
  logic [DW-1:0] ad_in;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ad_in,
    input  ack0, ack1, rdata, busy, gnt_id, ce_n, we_n, oe_n, ad_out, ad_oe
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ad_in,
    output ack0, ack1, rdata, busy, gnt_id, ce_n, we_n, oe_n, ad_out, ad_oe
  );
endinterface

// File: rtl/dpram_port_sequencer.sv
// One port of a multiplexed-AD dual-port RAM shared by two requesters with
// round-robin arbitration. Generates address setup/latch, write/read strobe
// timing and AD bus direction. Every output is registered.
module dpram_port_sequencer #(
  parameter int unsigned AW          = 8,
  parameter int unsigned DW          = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  dpram_port_sequencer_if.slave   bus
);

  // Data-phase counter reload; a zero wait count behaves as one cycle.
  localparam logic [3:0] W_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASETUP,
    S_AHOLD,
    S_DATA,
    S_RECOVER
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ptr_q, ptr_d;
  logic          gnt_q, gnt_d;
  logic          lat_we_q, lat_we_d;
  logic [AW-1:0] lat_addr_q, lat_addr_d;
  logic [DW-1:0] lat_wdata_q, lat_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          busy_q, busy_d;
  logic          ce_n_q, ce_n_d;
  logic          we_n_q, we_n_d;
  logic          oe_n_q, oe_n_d;
  logic          ad_oe_q, ad_oe_d;
  logic [DW-1:0] ad_out_q, ad_out_d;
  logic          sel;

  // Next-state, arbitration and output decode. Outputs are decoded from the
  // next state and next latched fields so the registered pins line up with
  // the state they belong to (ASETUP drives the address right after grant).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    rdata_d     = rdata_q;
    sel         = (bus.req0 && bus.req1) ? ptr_q : bus.req1;

    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          gnt_d       = sel;
          ptr_d       = ~sel;
          lat_we_d    = sel ? bus.we1    : bus.we0;
          lat_addr_d  = sel ? bus.addr1  : bus.addr0;
          lat_wdata_d = sel ? bus.wdata1 : bus.wdata0;
          state_d     = S_ASETUP;
        end
      end
      S_ASETUP: state_d = S_AHOLD;
      S_AHOLD: begin
        cnt_d   = W_LAST;
        state_d = S_DATA;
      end
      S_DATA: begin
        if (cnt_q == 4'd0) begin
          if (!lat_we_q) rdata_d = bus.ad_in;
          state_d = S_RECOVER;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE);
    ce_n_d  = !((state_d == S_AHOLD) || (state_d == S_DATA));
    we_n_d  = !((state_d == S_DATA) && lat_we_d);
    oe_n_d  = !((state_d == S_DATA) && !lat_we_d);
    ad_oe_d = (state_d == S_ASETUP) || (state_d == S_AHOLD) ||
              ((state_d == S_DATA) && lat_we_d);
    ack0_d  = (state_d == S_RECOVER) && !gnt_d;
    ack1_d  = (state_d == S_RECOVER) &&  gnt_d;

    if ((state_d == S_ASETUP) || (state_d == S_AHOLD))
      ad_out_d = DW'(lat_addr_d);
    else if ((state_d == S_DATA) && lat_we_d)
      ad_out_d = lat_wdata_d;
    else
      ad_out_d = '0;
  end

  // State, latched transaction fields and registered pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ptr_q       <= 1'b0;
      gnt_q       <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      rdata_q     <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      busy_q      <= 1'b0;
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      ad_oe_q     <= 1'b0;
      ad_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      rdata_q     <= rdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      busy_q      <= busy_d;
      ce_n_q      <= ce_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      ad_oe_q     <= ad_oe_d;
      ad_out_q    <= ad_out_d;
    end
  end

  assign bus.ack0   = ack0_q;
  assign bus.ack1   = ack1_q;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = busy_q;
  assign bus.gnt_id = gnt_q;
  assign bus.ce_n   = ce_n_q;
  assign bus.we_n   = we_n_q;
  assign bus.oe_n   = oe_n_q;
  assign bus.ad_oe  = ad_oe_q;
  assign bus.ad_out = ad_out_q;

endmodule

// File: tb/tb_dpram_port_sequencer.sv
// Bench for dpram_port_sequencer: cycle vectors for reset, write and
// read-back, then hand sequences for contention, back-to-back and reset
// in the data phase. A small RAM model sits on the AD pad.
module tb_dpram_port_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  dpram_port_sequencer_if #(.AW(8), .DW(8)) bus ();

  dpram_port_sequencer #(.AW(8), .DW(8), .WAIT_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM model: address latched on CE_ falling, write while CE_ and WE_ low,
  // drives AD while CE_ and OE_ low.
  logic [7:0] mem [256];
  logic [7:0] ram_addr = 8'h00;

  always @(negedge bus.ce_n) ram_addr = bus.ad_out;

  always @(posedge clk)
    if (bus.ce_n === 1'b0 && bus.we_n === 1'b0) mem[ram_addr] <= bus.ad_out;

  assign bus.ad_in = bus.ad_oe ? bus.ad_out :
                     ((bus.ce_n == 1'b0 && bus.oe_n == 1'b0) ? mem[ram_addr] : 8'hFF);

  typedef struct {
    logic       rst, req0, we0;
    logic [7:0] addr0, wdata0;
    logic       req1, we1;
    logic [7:0] addr1;
    logic       busy, gnt, ce_n, we_n, oe_n, ad_oe;
    logic [7:0] ad_out;
    logic       ack0, ack1;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs [15];

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int ack_t [4];
  int ack_id [4];
  int nacks;
  int viol;
  int lat;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 8'h00; bus.addr1 = 8'h00; bus.wdata0 = 8'h00; bus.wdata1 = 8'h00;
    rst = 1'b1;

    //            rst  rq0  we0  addr0  wdat0  rq1  we1  addr1 | busy gnt  ce   we   oe   adoe adout  ack0 ack1 rdata
    vecs[0]  = '{1'b1,1'b1,1'b1,8'h3C,8'hA5,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,8'h00,1'b0,1'b0,8'h00};
    vecs[1]  = vecs[0];
    vecs[2]  = vecs[0];
    vecs[3]  = '{1'b0,1'b1,1'b1,8'h3C,8'hA5,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,8'h3C,1'b0,1'b0,8'h00};
    vecs[4]  = '{1'b0,1'b1,1'b1,8'h3C,8'hA5,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b1,1'b1,1'b1,8'h3C,1'b0,1'b0,8'h00};
    vecs[5]  = '{1'b0,1'b1,1'b1,8'h3C,8'hA5,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,8'hA5,1'b0,1'b0,8'h00};
    vecs[6]  = vecs[5];
    vecs[7]  = '{1'b0,1'b1,1'b1,8'h3C,8'hA5,1'b0,1'b0,8'h00, 1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,8'h00,1'b1,1'b0,8'h00};
    vecs[8]  = '{1'b0,1'b0,1'b1,8'h3C,8'hA5,1'b0,1'b0,8'h00, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,8'h00,1'b0,1'b0,8'h00};
    vecs[9]  = '{1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h3C, 1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,8'h3C,1'b0,1'b0,8'h00};
    vecs[10] = '{1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h3C, 1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,8'h3C,1'b0,1'b0,8'h00};
    vecs[11] = '{1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h3C, 1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,8'h00,1'b0,1'b0,8'h00};
    vecs[12] = vecs[11];
    vecs[13] = '{1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,8'h3C, 1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,8'h00,1'b0,1'b1,8'hA5};
    vecs[14] = '{1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,8'h3C, 1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,8'h00,1'b0,1'b0,8'hA5};

    // Reset, write 0x3C<=0xA5 from requester 0, read it back on requester 1.
    for (int i = 0; i < 15; i++) begin
      rst = vecs[i].rst;
      bus.req0 = vecs[i].req0; bus.we0 = vecs[i].we0;
      bus.addr0 = vecs[i].addr0; bus.wdata0 = vecs[i].wdata0;
      bus.req1 = vecs[i].req1; bus.we1 = vecs[i].we1; bus.addr1 = vecs[i].addr1;
      tick();
      chk($sformatf("v%0d busy", i),  8'(bus.busy),  8'(vecs[i].busy));
      if (vecs[i].busy) chk($sformatf("v%0d gnt_id", i), 8'(bus.gnt_id), 8'(vecs[i].gnt));
      chk($sformatf("v%0d ce_n", i),  8'(bus.ce_n),  8'(vecs[i].ce_n));
      chk($sformatf("v%0d we_n", i),  8'(bus.we_n),  8'(vecs[i].we_n));
      chk($sformatf("v%0d oe_n", i),  8'(bus.oe_n),  8'(vecs[i].oe_n));
      chk($sformatf("v%0d ad_oe", i), 8'(bus.ad_oe), 8'(vecs[i].ad_oe));
      if (vecs[i].ad_oe) chk($sformatf("v%0d ad_out", i), bus.ad_out, vecs[i].ad_out);
      chk($sformatf("v%0d ack0", i),  8'(bus.ack0),  8'(vecs[i].ack0));
      chk($sformatf("v%0d ack1", i),  8'(bus.ack1),  8'(vecs[i].ack1));
      chk($sformatf("v%0d rdata", i), bus.rdata,     vecs[i].rdata);
    end

    // Contention: both requesters write continuously; expect 0,1,0,1.
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h10; bus.wdata0 = 8'h11;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h20; bus.wdata1 = 8'h22;
    nacks = 0; viol = 0;
    for (int c = 0; c < 60 && nacks < 4; c++) begin
      tick();
      if ((bus.ad_oe && !bus.oe_n) || (!bus.we_n && !bus.oe_n)) viol++;
      if (bus.ack0 || bus.ack1) begin
        ack_t[nacks]  = cyc;
        ack_id[nacks] = bus.ack1 ? 1 : 0;
        chk($sformatf("cont ack%0d single", nacks), 8'(bus.ack0 && bus.ack1), 8'd0);
        chk($sformatf("cont ack%0d gnt_id", nacks), 8'(bus.gnt_id), 8'(ack_id[nacks]));
        nacks++;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    chk("cont ack count", 8'(nacks), 8'd4);
    for (int k = 0; k < nacks; k++) chk($sformatf("cont order%0d", k), 8'(ack_id[k]), 8'(k % 2));
    for (int k = 1; k < nacks; k++) chk($sformatf("cont spacing%0d", k), 8'(ack_t[k] - ack_t[k-1]), 8'd6);
    chk("cont strobe overlap", 8'(viol), 8'd0);
    tick();
    chk("cont mem10", mem[8'h10], 8'h11);
    chk("cont mem20", mem[8'h20], 8'h22);
    chk("rdata kept over writes", bus.rdata, 8'hA5);

    // Back-to-back: requester 0 alone for three transactions.
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h30; bus.wdata0 = 8'h33;
    nacks = 0;
    for (int c = 0; c < 60 && nacks < 3; c++) begin
      tick();
      chk($sformatf("b2b ack1 c%0d", c), 8'(bus.ack1), 8'd0);
      if (bus.ack0) begin
        ack_t[nacks] = cyc;
        nacks++;
      end
    end
    bus.req0 = 1'b0;
    chk("b2b ack count", 8'(nacks), 8'd3);
    for (int k = 1; k < nacks; k++) chk($sformatf("b2b spacing%0d", k), 8'(ack_t[k] - ack_t[k-1]), 8'd6);
    tick();

    // Reset during the data phase of a write.
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 8'h55; bus.wdata0 = 8'h77;
    tick(); tick(); tick();
    chk("midrst pre we_n", 8'(bus.we_n), 8'd0);
    rst = 1'b1;
    tick();
    chk("midrst ce_n",  8'(bus.ce_n),  8'd1);
    chk("midrst we_n",  8'(bus.we_n),  8'd1);
    chk("midrst ad_oe", 8'(bus.ad_oe), 8'd0);
    chk("midrst ack0",  8'(bus.ack0),  8'd0);
    chk("midrst busy",  8'(bus.busy),  8'd0);
    rst = 1'b0;
    bus.addr0 = 8'h56; bus.wdata0 = 8'h78;
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.ack0) begin
        lat = c + 1;
        break;
      end
    end
    chk("midrst next latency", 8'(lat), 8'd5);
    bus.req0 = 1'b0;
    tick();
    chk("midrst next mem56", mem[8'h56], 8'h78);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
